// File: rtl/if_id_skid_pipeline_reg.sv
// if_id_skid_pipeline_reg: IF/ID register with valid/ready handshake, one-entry skid buffer, flush and saturating stall counter.
module if_id_skid_pipeline_reg #(
  parameter int          XLEN            = 32,
  parameter int          INSTR_WIDTH     = 32,
  parameter logic [31:0] RESET_PC        = 32'hFFFFFFFC,
  parameter logic [31:0] BUBBLE_INSTR    = 32'h00000000,
  parameter int          STALL_CNT_WIDTH = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [INSTR_WIDTH-1:0]     IN_INSTRUCTION,
  input  logic [XLEN-1:0]            IN_PC,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  output logic [INSTR_WIDTH-1:0]     OUT_INSTRUCTION,
  output logic [XLEN-1:0]            OUT_PC,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  input  logic                       FLUSH,
  output logic [STALL_CNT_WIDTH-1:0] STALL_COUNT
);
  localparam logic [XLEN-1:0]            RST_PC    = XLEN'(RESET_PC);
  localparam logic [INSTR_WIDTH-1:0]     BUBBLE    = INSTR_WIDTH'(BUBBLE_INSTR);
  localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = '1;
  logic                       main_valid_q, main_valid_d;
  logic [INSTR_WIDTH-1:0]     main_instr_q, main_instr_d;
  logic [XLEN-1:0]            main_pc_q, main_pc_d;
  logic                       skid_valid_q, skid_valid_d;
  logic [INSTR_WIDTH-1:0]     skid_instr_q, skid_instr_d;
  logic [XLEN-1:0]            skid_pc_q, skid_pc_d;
  logic                       in_ready_q, in_ready_d;
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;
  logic                       accept, consume;
  assign accept          = IN_VALID & in_ready_q;
  assign consume         = main_valid_q & OUT_READY;
  assign IN_READY        = in_ready_q;
  assign OUT_VALID       = main_valid_q;
  assign OUT_INSTRUCTION = main_instr_q;
  assign OUT_PC          = main_pc_q;
  assign STALL_COUNT     = stall_q;
  always_comb begin
    main_valid_d = main_valid_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (FLUSH) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_instr_d = BUBBLE;
    end else if (consume) begin
      if (skid_valid_q) begin
        main_instr_d = skid_instr_q;
        main_pc_d    = skid_pc_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_instr_d = IN_INSTRUCTION;
        main_pc_d    = IN_PC;
      end else begin
        main_valid_d = 1'b0;
        main_instr_d = BUBBLE;
      end
    end else if (accept) begin
      // Decode is stalled on a held entry: park the newcomer in the skid slot.
      if (main_valid_q) begin
        skid_valid_d = 1'b1;
        skid_instr_d = IN_INSTRUCTION;
        skid_pc_d    = IN_PC;
      end else begin
        main_valid_d = 1'b1;
        main_instr_d = IN_INSTRUCTION;
        main_pc_d    = IN_PC;
      end
    end
    in_ready_d = ~skid_valid_d;
    stall_d    = (main_valid_q && !OUT_READY && stall_q != STALL_MAX) ? stall_q + STALL_CNT_WIDTH'(1) : stall_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      main_valid_q <= 1'b0;
      main_instr_q <= BUBBLE;
      main_pc_q    <= RST_PC;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      in_ready_q   <= 1'b1;
      stall_q      <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      in_ready_q   <= in_ready_d;
      stall_q      <= stall_d;
    end
  end
endmodule
